// File: rtl/aes_enc_core.sv
// rtl/aes_enc_core.sv - iterative AES-128 encryption core, one round per two cycles.
// Round keys come from an external key_expansion stepped by start_enc/ready_enc.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
  always_comb begin
    logic [7:0] sq;
    sq  = gf_mul(in_byte, in_byte);
    inv = sq;
    for (int k = 2; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_enc_core #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pt_valid,
  output logic         pt_ready,
  input  logic [127:0] pt_data,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [127:0] ct_data,
  output logic         start_enc,
  output logic         ready_enc,
  input  logic [127:0] key_enc,
  output logic         busy
);
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_rounds
    $error("aes_enc_core: NUM_ROUNDS must be in 1..10");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_KEY0, S_STEP, S_ROUND, S_DONE
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] sb_out, sr_out, mc_out, round_out;
  logic         last_rnd;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (state_q[127-8*i -: 8]),
      .out_byte (sb_out[127-8*i -: 8])
    );
  end

  // Byte 4*c+r sits at row r, column c; row r rotates left by r columns.
  always_comb begin
    sr_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_out[127-8*(4*c+r) -: 8] = sb_out[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mc_out = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr_out[127-32*c -: 8];
      a1 = sr_out[119-32*c -: 8];
      a2 = sr_out[111-32*c -: 8];
      a3 = sr_out[103-32*c -: 8];
      mc_out[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc_out[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc_out[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc_out[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  assign last_rnd  = (rnd_q == LAST_RND);
  assign round_out = last_rnd ? sr_out : mc_out;
  assign ct_data   = ct_q;
  assign busy      = (fsm_q != S_IDLE);

  always_comb begin
    fsm_d     = fsm_q;
    rnd_d     = rnd_q;
    state_d   = state_q;
    ct_d      = ct_q;
    pt_ready  = 1'b0;
    ct_valid  = 1'b0;
    start_enc = 1'b0;
    ready_enc = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        pt_ready = 1'b1;
        if (pt_valid) begin
          state_d = pt_data;
          fsm_d   = S_INIT;
        end
      end
      S_INIT: begin
        start_enc = 1'b1;
        fsm_d     = S_KEY0;
      end
      S_KEY0: begin
        state_d = state_q ^ key_enc;
        rnd_d   = 4'd1;
        fsm_d   = S_STEP;
      end
      S_STEP: begin
        ready_enc = 1'b1;
        fsm_d     = S_ROUND;
      end
      S_ROUND: begin
        state_d = round_out ^ key_enc;
        if (last_rnd) begin
          ct_d  = round_out ^ key_enc;
          fsm_d = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
          fsm_d = S_STEP;
        end
      end
      S_DONE: begin
        ct_valid = 1'b1;
        if (ct_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      ct_q    <= ct_d;
    end
  end
endmodule

// File: tb/tb_aes_enc_core.sv
// tb/tb_aes_enc_core.sv - directed FIPS-197 vectors against aes_enc_core.
// A behavioural key_expansion per DUT serves round keys from start_enc/ready_enc.

module tb_aes_enc_core;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT1R = 128'hb5f99471dbcf93fe17d6cfa06c61a619;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pt_valid = 1'b0, ct_ready = 1'b1;
  logic [127:0] pt_data = '0;
  logic         pt_ready, ct_valid, start_enc, ready_enc, busy;
  logic [127:0] ct_data, key_enc;
  logic         pt_valid1 = 1'b0, ct_ready1 = 1'b1;
  logic [127:0] pt_data1 = '0;
  logic         pt_ready1, ct_valid1, start_enc1, ready_enc1, busy1;
  logic [127:0] ct_data1, key_enc1;

  logic [127:0] rk [0:10];
  int cyc = 0;
  int n_checks = 0, n_pass = 0;
  int ke_idx = 0, n_rise = 0, n_start = 0;
  int ke_idx1 = 0;
  logic rdy_prev = 1'b0, rdy_prev1 = 1'b0;

  aes_enc_core #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_data(pt_data), .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .start_enc(start_enc), .ready_enc(ready_enc), .key_enc(key_enc), .busy(busy)
  );

  aes_enc_core #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pt_valid(pt_valid1), .pt_ready(pt_ready1),
    .pt_data(pt_data1), .ct_valid(ct_valid1), .ct_ready(ct_ready1), .ct_data(ct_data1),
    .start_enc(start_enc1), .ready_enc(ready_enc1), .key_enc(key_enc1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (start_enc) ke_idx <= 0;
    else if (ready_enc && !rdy_prev && ke_idx < 10) ke_idx <= ke_idx + 1;
    if (ready_enc && !rdy_prev) n_rise <= n_rise + 1;
    if (start_enc) n_start <= n_start + 1;
    rdy_prev <= ready_enc;
  end
  assign key_enc = rk[ke_idx];

  always @(posedge clk) begin
    if (start_enc1) ke_idx1 <= 0;
    else if (ready_enc1 && !rdy_prev1 && ke_idx1 < 10) ke_idx1 <= ke_idx1 + 1;
    rdy_prev1 <= ready_enc1;
  end
  assign key_enc1 = rk[ke_idx1];

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++)
      if (tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
    return s ^ 8'h63;
  endfunction

  task automatic set_new_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
        t = t ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", tag, got, exp);
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    $display("FAIL %s: timed out waiting on DUT", tag);
  endtask

  // Called at a negedge; returns the handshake cycle.
  task automatic send(input logic [127:0] pt, output int hs);
    hs = -1;
    pt_data  = pt;
    pt_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (pt_ready) begin
        hs = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) timeout("accept");
    @(negedge clk);
    pt_valid = 1'b0;
  endtask

  task automatic wait_ct(output int t, output logic bad_ready);
    t = -1;
    bad_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ct_valid) begin
        t = cyc;
        break;
      end
      if (pt_ready) bad_ready = 1'b1;
      @(negedge clk);
    end
    if (t < 0) timeout("ct_valid");
  endtask

  initial begin
    int hs, t, hs1, hs2, t1, t2, r0, s0;
    logic bad, got1, stable;
    logic [127:0] held, ct1;

    set_new_key(K1);
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, ct_valid, start_enc, ready_enc}, 4'b0000);
    check("rst_ct_data", ct_data, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pt_ready", pt_ready, 1'b1);

    r0 = n_rise; s0 = n_start;
    send(PT1, hs);
    wait_ct(t, bad);
    check("c1_ct", ct_data, CT1);
    check("c1_latency", 128'(t - hs), 128'd23);
    check("c1_no_pt_ready_busy", bad, 1'b0);
    check("c1_ready_edges", 128'(n_rise - r0), 128'd10);
    @(negedge clk);
    check("c1_back_idle", {busy, ct_valid, pt_ready}, 3'b001);

    set_new_key(K2);
    r0 = n_rise; s0 = n_start;
    send(PT2, hs);
    wait_ct(t, bad);
    check("b_ct", ct_data, CT2);
    check("b_ready_edges", 128'(n_rise - r0), 128'd10);
    check("b_start_pulses", 128'(n_start - s0), 128'd1);
    @(negedge clk);

    ct_ready = 1'b0;
    send(PT2, hs);
    wait_ct(t, bad);
    held = ct_data;
    stable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (!ct_valid || ct_data !== held || pt_ready) stable = 1'b0;
    end
    check("bp_stable", stable, 1'b1);
    check("bp_ct", held, CT2);
    ct_ready = 1'b1;
    @(negedge clk);
    check("bp_to_idle", {busy, ct_valid, pt_ready}, 3'b001);
    check("idle_ct_hold", ct_data, CT2);

    set_new_key(K1);
    send(PT1, hs);
    bad = 1'b0;
    while (cyc < hs + 11) begin
      if (ct_valid) bad = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    if (ct_valid) bad = 1'b1;
    check("mid_rst_idle", {busy, ct_valid, start_enc, ready_enc}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_no_ct", bad, 1'b0);
    send(PT1, hs);
    wait_ct(t, bad);
    check("mid_rst_resubmit_ct", ct_data, CT1);
    @(negedge clk);

    hs1 = -1; hs2 = -1; t1 = -1; got1 = 1'b0; ct1 = '0;
    pt_data = PT1;
    pt_valid = 1'b1;
    for (int i = 0; i < 100 && hs1 < 0; i++) begin
      if (pt_ready) hs1 = cyc;
      else @(negedge clk);
    end
    @(negedge clk);
    pt_data = PT2;
    for (int i = 0; i < 100 && hs2 < 0; i++) begin
      if (ct_valid && !got1) begin
        got1 = 1'b1;
        ct1 = ct_data;
        t1 = cyc;
        set_new_key(K2);
      end
      if (pt_ready) hs2 = cyc;
      else @(negedge clk);
    end
    if (hs1 < 0 || hs2 < 0) timeout("b2b_accept");
    @(negedge clk);
    pt_valid = 1'b0;
    wait_ct(t2, bad);
    check("b2b_ct1", ct1, CT1);
    check("b2b_lat1", 128'(t1 - hs1), 128'd23);
    check("b2b_accept_gap", 128'(hs2 - hs1), 128'd24);
    check("b2b_ct2", ct_data, CT2);
    @(negedge clk);

    set_new_key(K1);
    hs = -1; t = -1;
    pt_data1 = PT1;
    pt_valid1 = 1'b1;
    for (int i = 0; i < 50 && hs < 0; i++) begin
      if (pt_ready1) hs = cyc;
      else @(negedge clk);
    end
    @(negedge clk);
    pt_valid1 = 1'b0;
    for (int i = 0; i < 50 && t < 0; i++) begin
      if (ct_valid1) t = cyc;
      else @(negedge clk);
    end
    if (hs < 0 || t < 0) timeout("r1_handshake");
    check("r1_ct", ct_data1, CT1R);
    check("r1_latency", 128'(t - hs), 128'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/aes_enc_core.md
AES_ENC_CORE -- requirements
Module: aes_enc_core

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, giving the number of cipher rounds; the legal range is 1..10, and synthesis with any other value SHALL fail.
REQ-002 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  Reset; it is synchronous and active-low.
REQ-004 pt_valid  input  1  Plaintext block offered.
REQ-005 pt_ready  output  1  The block accepts plaintext.
REQ-006 pt_data  input  128  Plaintext, with byte 0 in [127:120] and bytes in FIPS-197 column-major order.
REQ-007 ct_valid  output  1  Ciphertext is available.
REQ-008 ct_ready  input  1  The consumer accepts the ciphertext.
REQ-009 ct_data  output  128  Ciphertext, using the same byte order as pt_data.
REQ-010 start_enc  output  1  Rewinds the upstream key_expansion to the round-0 key.
REQ-011 ready_enc  output  1  Each rising edge of this signal advances key_expansion by one round key.
REQ-012 key_enc  input  128  Current round key from key_expansion.
REQ-013 busy  output  1  High in every state except IDLE.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, INIT, KEY0, STEP, ROUND and DONE, plus a 4-bit round counter rnd.
REQ-015 IDLE: pt_ready=1; when pt_valid=1, the block SHALL capture pt_data into the 128-bit state register and go to INIT.
REQ-016 INIT: start_enc=1 for exactly this one cycle; the next state SHALL be KEY0.
REQ-017 KEY0: the state register SHALL load state XOR key_enc (the round-0 AddRoundKey); rnd SHALL be set to 1; the next state SHALL be STEP.
REQ-018 STEP: ready_enc=1 for exactly this one cycle; the next state SHALL be ROUND.
REQ-019 ROUND: ready_enc=0; the state register SHALL load AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key_enc).
REQ-020 The MixColumns step SHALL be omitted when rnd==NUM_ROUNDS.
REQ-021 In ROUND, if rnd==NUM_ROUNDS the next state SHALL be DONE; otherwise rnd SHALL increment and the next state SHALL be STEP.
REQ-022 ready_enc SHALL be low for at least one cycle between consecutive high cycles, so key_expansion sees exactly one rising edge per round.
REQ-023 key_enc SHALL be sampled only in KEY0 and ROUND, i.e. at least one full cycle after the start_enc or ready_enc edge that changed it.
REQ-024 SubBytes SHALL use 16 instances of the existing combinational aes_sbox (8-bit in, 8-bit out).
REQ-025 MixColumns SHALL use xtime over GF(2^8) with polynomial 0x11B.
REQ-026 DONE: ct_valid=1 and ct_data=state; while ct_ready=0, both SHALL be held stable; when ct_ready=1, the block SHALL go to IDLE.
REQ-027 ct_data SHALL keep its last value in IDLE.
REQ-028 With ct_ready held high, latency SHALL be 3+2*NUM_ROUNDS cycles from the pt handshake cycle to the first ct_valid cycle, i.e. 23 for NUM_ROUNDS=10.
REQ-029 Throughput SHALL be one block per 4+2*NUM_ROUNDS cycles; no overlap of blocks is permitted.
REQ-030 pt_ready SHALL be 0 outside IDLE; pt_valid in those states SHALL be ignored and SHALL NOT be captured later unless still asserted in IDLE.
REQ-031 The ct handshake and a new pt handshake SHALL NOT complete in the same cycle; pt is accepted no earlier than the cycle after DONE exits.
REQ-032 pt_data and key_enc changes outside their sampling cycles SHALL NOT affect the result.

Reset
REQ-033 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and rnd=0, state=0, ct_data=0, ct_valid=0, start_enc=0, ready_enc=0, busy=0; pt_ready SHALL be 1 from the first cycle after reset is released.
REQ-034 Reset mid-operation SHALL abort the block with no ct_valid issued; key_expansion is not reset by this block, and the next block's INIT start_enc SHALL resynchronise it.

Verification
REQ-035 FIPS-197 C.1, with key_expansion loaded with key 000102030405060708090a0b0c0d0e0f: pt 00112233445566778899aabbccddeeff -> ct_data 69c4e0d86a7b0430d8cdb78070b4c55a, with ct_valid exactly 23 cycles after accept.
REQ-036 FIPS-197 Appendix B, key 2b7e151628aed2a6abf7158809cf4f3c: pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32; the bench SHALL count exactly 10 ready_enc rising edges and 1 start_enc pulse.
REQ-037 Back-pressure: ct_ready held 0 for 15 cycles in DONE -> ct_valid and ct_data stable and pt_ready=0 throughout; one ct_ready cycle -> IDLE on the next cycle.
REQ-038 Reset at round 5 (rnd=5), then the C.1 block resubmitted -> no ct_valid before reset, and the correct C.1 ciphertext afterwards.
REQ-039 Two back-to-back blocks (C.1 pt, then Appendix B pt, with the key switched via set_new_key in between) with pt_valid held high -> second accept exactly 24 cycles after the first, and both ciphertexts correct.
REQ-040 NUM_ROUNDS=1, key 000102...0f, pt 00112233...ff -> ct equals the FIPS-197 C.1 round-1 state with MixColumns omitted, XOR the round-1 key; ct_valid 5 cycles after accept.
